// File: rtl/ddram_scan_reader.sv
// ddram_scan_reader: burst-reads a DDR3 word range and checks every beat.
// Optional CRC-32 over all received beats when DDRAM_SCAN_CRC_EN is defined.
module ddram_scan_reader #(
  parameter int unsigned BURST  = 128,
  parameter logic [63:0] EXPECT = 64'h0,
  parameter int unsigned ERRW   = 16
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            start,
  input  logic [28:0]     base,
  input  logic [28:0]     len,
  input  logic            DDRAM_BUSY,
  output logic [7:0]      DDRAM_BURSTCNT,
  output logic [28:0]     DDRAM_ADDR,
  output logic            DDRAM_RD,
  input  logic [63:0]     DDRAM_DOUT,
  input  logic            DDRAM_DOUT_READY,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_cnt,
  output logic [28:0]     err_addr
`ifdef DDRAM_SCAN_CRC_EN
  ,
  output logic [31:0]     crc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_FIN
  } state_t;

  localparam logic [28:0] BURST_W = 29'(BURST);

  state_t      state;
  state_t      state_nx;
  logic [28:0] cur;
  logic [28:0] rem;
  logic [28:0] rem_nx;
  logic [7:0]  beats;
  logic [7:0]  idx;
  logic [7:0]  burst_len;
  logic        seen;
  logic        beat;
  logic        last;
  logic        miss;

  assign burst_len = (rem < BURST_W) ? rem[7:0] : BURST_W[7:0];
  assign beat      = (state == S_DATA) && DDRAM_DOUT_READY;
  assign last      = beat && (idx == beats - 8'd1);
  assign miss      = beat && (DDRAM_DOUT != EXPECT);
  assign rem_nx    = rem - {21'd0, beats};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    DDRAM_RD       = 1'b0;
    DDRAM_ADDR     = '0;
    DDRAM_BURSTCNT = '0;
    busy           = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = (len == '0) ? S_FIN : S_REQ;
      end
      S_REQ: begin
        busy           = 1'b1;
        DDRAM_RD       = 1'b1;
        DDRAM_ADDR     = cur;
        DDRAM_BURSTCNT = burst_len;
        if (!DDRAM_BUSY) state_nx = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (last) state_nx = (rem_nx != '0) ? S_REQ : S_FIN;
      end
      S_FIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= '0;
      rem      <= '0;
      beats    <= '0;
      idx      <= '0;
      seen     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        cur      <= base;
        rem      <= len;
        seen     <= 1'b0;
        done     <= 1'b0;
        pass     <= 1'b0;
        err_cnt  <= '0;
        err_addr <= '0;
      end
      if (state == S_REQ && !DDRAM_BUSY) begin
        beats <= burst_len;
        idx   <= '0;
      end
      if (miss) begin
        if (err_cnt != {ERRW{1'b1}}) err_cnt <= err_cnt + ERRW'(1);
        if (!seen) begin
          seen     <= 1'b1;
          err_addr <= cur + {21'd0, idx};
        end
      end
      if (last) begin
        cur <= cur + {21'd0, beats};
        rem <= rem_nx;
      end else if (beat) begin
        idx <= idx + 8'd1;
      end
      if (state == S_FIN) begin
        done <= 1'b1;
        pass <= (err_cnt == '0);
      end
    end
  end

`ifdef DDRAM_SCAN_CRC_EN
  // Non-reflected CRC-32, bytes fed low byte first, MSB of each byte first.
  function automatic logic [31:0] crc_beat(input logic [31:0] c,
                                           input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      r = r ^ {d[8*b +: 8], 24'd0};
      for (int k = 0; k < 8; k++)
        r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                      crc <= 32'hFFFFFFFF;
    else if (state == S_IDLE && start) crc <= 32'hFFFFFFFF;
    else if (beat)                     crc <= crc_beat(crc, DDRAM_DOUT);
  end
`endif

endmodule

// File: tb/tb_ddram_scan_reader.sv
// tb_ddram_scan_reader: table-driven scans against a negedge DDR3 responder.
// Hand sequences cover stall hold, len=0, reset mid-burst and optional CRC.
module tb_ddram_scan_reader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [28:0] base = '0;
  logic [28:0] len = '0;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  err_cnt;
  logic [28:0] err_addr;
`ifdef DDRAM_SCAN_CRC_EN
  logic [31:0] crc;
`endif

  ddram_scan_reader #(
    .BURST (128),
    .EXPECT(64'h0),
    .ERRW  (3)
  ) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .start           (start),
    .base            (base),
    .len             (len),
    .DDRAM_BUSY      (DDRAM_BUSY),
    .DDRAM_BURSTCNT  (DDRAM_BURSTCNT),
    .DDRAM_ADDR      (DDRAM_ADDR),
    .DDRAM_RD        (DDRAM_RD),
    .DDRAM_DOUT      (DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .err_addr        (err_addr)
`ifdef DDRAM_SCAN_CRC_EN
    ,
    .crc             (crc)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail = 0;

  // memory fault model
  bit          c_en = 1'b0;
  logic [28:0] c_addr = '0;
  bit          c_odd = 1'b0;

  // responder state
  bit          flush = 1'b0;
  int          beats_left = 0;
  int          lat = 0;
  logic [28:0] r_addr = '0;
  int          beats_driven = 0;
  int          rd_seen = 0;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  logic [28:0] stall_addr = '0;
  logic [7:0]  stall_cnt = '0;
  logic [28:0] log_addr[$];
  logic [7:0]  log_cnt[$];

  function automatic logic [63:0] mem_word(input logic [28:0] a);
    if ((c_en && a == c_addr) || (c_odd && a[0])) return 64'hDEAD;
    return 64'h0;
  endfunction

  always @(negedge clk_sys) begin
    DDRAM_DOUT_READY = 1'b0;
    DDRAM_BUSY = 1'b0;
    if (flush) begin
      beats_left = 0;
      lat = 0;
    end else if (beats_left != 0) begin
      if (lat != 0) lat--;
      else begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = mem_word(r_addr);
        r_addr = r_addr + 29'd1;
        beats_left--;
        beats_driven++;
      end
    end else if (DDRAM_RD) begin
      rd_seen++;
      if (stall_left != 0) begin
        DDRAM_BUSY = 1'b1;
        stall_left--;
        stall_seen++;
        if (DDRAM_ADDR !== stall_addr || DDRAM_BURSTCNT !== stall_cnt)
          stall_bad++;
      end else begin
        log_addr.push_back(DDRAM_ADDR);
        log_cnt.push_back(DDRAM_BURSTCNT);
        beats_left = int'(DDRAM_BURSTCNT);
        r_addr = DDRAM_ADDR;
        lat = 2;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_scan(input logic [28:0] b, input logic [28:0] l);
    int n;
    @(negedge clk_sys);
    base = b;
    len = l;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk_sys);
      n++;
    end
    check("scan_done", done, 1);
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c,
                                          input logic [63:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      for (int k = 7; k >= 0; k--) begin
        if (r[31] ^ d[8*b + k]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
        else                    r = {r[30:0], 1'b0};
      end
    end
    return r;
  endfunction

  typedef struct {
    logic [28:0] base;
    logic [28:0] len;
    bit          c_en;
    logic [28:0] c_addr;
    bit          c_odd;
    bit          exp_pass;
    int          exp_err;
    logic [28:0] exp_eaddr;
    int          exp_bursts;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{29'd0, 29'd300, 1'b0, 29'd0, 1'b0, 1'b1, 0, 29'd0, 3};
    vecs[1] = '{29'd0, 29'd256, 1'b1, 29'd200, 1'b0, 1'b0, 1, 29'd200, 2};
    vecs[2] = '{29'd1000, 29'd5, 1'b1, 29'd1004, 1'b0, 1'b0, 1, 29'd1004, 1};
    vecs[3] = '{29'h1FFFFFFD, 29'd6, 1'b1, 29'd1, 1'b0, 1'b0, 1, 29'd1, 1};
    vecs[4] = '{29'd10, 29'd128, 1'b0, 29'd0, 1'b0, 1'b1, 0, 29'd0, 1};
    vecs[5] = '{29'd10, 29'd129, 1'b0, 29'd0, 1'b0, 1'b1, 0, 29'd0, 2};
    vecs[6] = '{29'd4, 29'd10, 1'b0, 29'd0, 1'b1, 1'b0, 5, 29'd5, 1};
    vecs[7] = '{29'd0, 29'd30, 1'b0, 29'd0, 1'b1, 1'b0, 7, 29'd1, 1};

    repeat (3) @(negedge clk_sys);
    check("rst_rd", DDRAM_RD, 0);
    check("rst_cnt", DDRAM_BURSTCNT, 0);
    check("rst_addr", DDRAM_ADDR, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_errcnt", err_cnt, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    for (int i = 0; i < 8; i++) begin
      c_en = vecs[i].c_en;
      c_addr = vecs[i].c_addr;
      c_odd = vecs[i].c_odd;
      log_addr.delete();
      log_cnt.delete();
      run_scan(vecs[i].base, vecs[i].len);
      check($sformatf("v%0d_pass", i), pass, 64'(vecs[i].exp_pass));
      check($sformatf("v%0d_errcnt", i), err_cnt, 64'(vecs[i].exp_err));
      check($sformatf("v%0d_erraddr", i), err_addr, 64'(vecs[i].exp_eaddr));
      check($sformatf("v%0d_bursts", i), log_addr.size(),
            64'(vecs[i].exp_bursts));
      check($sformatf("v%0d_busy", i), busy, 0);
    end

    // len=0 right after a failing scan: clears status, issues no reads
    begin
      int rd0;
      rd0 = rd_seen;
      @(negedge clk_sys);
      base = 29'd77;
      len = 29'd0;
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      check("len0_done_clr", done, 0);
      check("len0_errcnt_clr", err_cnt, 0);
      check("len0_erraddr_clr", err_addr, 0);
      @(negedge clk_sys);
      check("len0_done", done, 1);
      check("len0_pass", pass, 1);
      check("len0_no_rd", rd_seen - rd0, 0);
    end

    // burst sequencing for a 300-word zero fill
    c_en = 1'b0;
    c_odd = 1'b0;
    log_addr.delete();
    log_cnt.delete();
    run_scan(29'd0, 29'd300);
    check("seq_bursts", log_addr.size(), 3);
    for (int k = 0; k < log_addr.size() && k < 3; k++) begin
      check($sformatf("seq_addr%0d", k), log_addr[k], 64'(k * 128));
      check($sformatf("seq_cnt%0d", k), log_cnt[k], (k == 2) ? 44 : 128);
    end

    // stall hold on the first request
    log_addr.delete();
    log_cnt.delete();
    stall_seen = 0;
    stall_bad = 0;
    stall_addr = 29'd50;
    stall_cnt = 8'd100;
    stall_left = 5;
    @(negedge clk_sys);
    base = 29'd50;
    len = 29'd100;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    check("stall_busy", busy, 1);
    begin
      int n;
      n = 0;
      while (!done && n < 5000) begin
        @(negedge clk_sys);
        n++;
      end
    end
    check("stall_done", done, 1);
    check("stall_cycles", stall_seen, 5);
    check("stall_stable", stall_bad, 0);
    check("stall_bursts", log_addr.size(), 1);
    check("stall_pass", pass, 1);

    // reset in the middle of a burst
    begin
      int b0;
      int n;
      c_odd = 1'b1;
      b0 = beats_driven;
      @(negedge clk_sys);
      base = 29'd0;
      len = 29'd300;
      start = 1'b1;
      @(negedge clk_sys);
      start = 1'b0;
      n = 0;
      while (beats_driven - b0 < 10 && n < 1000) begin
        @(negedge clk_sys);
        n++;
      end
      check("mid_beats", beats_driven - b0, 10);
      @(posedge clk_sys);
      #1;
      check("mid_pre_errcnt", err_cnt, 5);
      reset_n = 1'b0;
      flush = 1'b1;
      #1;
      check("mid_rd", DDRAM_RD, 0);
      check("mid_cnt", DDRAM_BURSTCNT, 0);
      check("mid_addr", DDRAM_ADDR, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_pass", pass, 0);
      check("mid_errcnt", err_cnt, 0);
      check("mid_erraddr", err_addr, 0);
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      flush = 1'b0;
      c_odd = 1'b0;
      run_scan(29'd0, 29'd16);
      check("post_rst_pass", pass, 1);
      check("post_rst_errcnt", err_cnt, 0);
    end

`ifdef DDRAM_SCAN_CRC_EN
    run_scan(29'd5, 29'd1);
    check("crc_first", crc, crc_ref(32'hFFFFFFFF, 64'h0));
    run_scan(29'd5, 29'd1);
    check("crc_again", crc, crc_ref(32'hFFFFFFFF, 64'h0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddram_scan_reader.md
Name: ddram_scan_reader

Overview:
- Read-side companion to the menu core's DDR3 clear writer.
- Bursts through a DDR3 word range and compares every 64-bit beat against an expected fill pattern.
- Reports pass/fail, error count and first failing address to the HPS status path.
- Sits on the same DDRAM_* port as the clear writer; the two are time-multiplexed: the writer runs first, then this block.

Parameters:
- BURST, 128, max beats per read burst (1..255).
- EXPECT, 64'h0, expected value of every 64-bit word.
- ERRW, 16, width of error counter (saturating).

Ports:
- clk_sys  in  1  system clock; DDR3 port clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins scan when idle.
- base  in  29  first word address (64-bit units).
- len  in  29  number of words to scan; 0 = no reads.
- DDRAM_BUSY  in  1  controller stall.
- DDRAM_BURSTCNT  out  8  beats requested.
- DDRAM_ADDR  out  29  burst start word address.
- DDRAM_RD  out  1  read request.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read data valid.
- busy  out  1  scan in progress.
- done  out  1  sticky; set at scan end, cleared by start.
- pass  out  1  valid when done; 1 = zero mismatches.
- err_cnt  out  ERRW  mismatch count, saturates at all-ones.
- err_addr  out  29  word address of first mismatch; 0 if none.

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0: RD, BURSTCNT, ADDR, busy, done, pass, err_cnt, err_addr. Internal counters cleared; any outstanding burst is abandoned.
- IDLE:
  - start=1 clears done, pass, err_cnt and err_addr; latches cur=base and rem=len.
  - If len=0: go to FIN on the next cycle.
  - Otherwise go to REQ; busy=1 from the cycle after start.
- REQ:
  - Drive RD=1, ADDR=cur, BURSTCNT=min(BURST,rem).
  - Hold all three stable while BUSY=1.
  - Request is accepted on the edge where RD=1 and BUSY=0. Next cycle: RD=0, beats=BURSTCNT, go to DATA.
- DATA:
  - Each DOUT_READY beat compares DOUT to EXPECT.
  - On mismatch: err_cnt+1 (saturating). If this is the first mismatch, err_addr = cur + beat index.
  - The last beat (beat index = beats-1): cur += beats, rem -= beats. Then go to REQ if rem≠0, else FIN.
  - A DOUT_READY arriving in the same cycle as the state transition is not possible by protocol; DOUT_READY outside DATA is ignored.
- FIN: one cycle. busy=0, done=1, pass=(err_cnt==0). Return to IDLE.
- Only one burst is outstanding at a time; no pipelined requests.
- start while busy=1 is ignored.
- Address arithmetic wraps modulo 2^29; base+len past 2^29 wraps to 0 with no error flag.
- Read latency is not bounded by this block; there is no timeout.

Optional Feature:
- Macro: DDRAM_SCAN_CRC_EN.
- Defined:
  - Adds output crc [31:0], a CRC-32 (poly 04C11DB7, init FFFFFFFF, no reflection, no final XOR) over every received beat.
  - Beats are processed little-endian byte order, byte 0 = DOUT[7:0], one beat per clock.
  - crc resets to FFFFFFFF on reset_n and on an accepted start. It is valid when done=1.
- Undefined: no crc port and no CRC logic; all other behaviour is identical.

Test Plan:
- Zero fill: base=0, len=300, BURST=128, all DOUT=0, BUSY=0 → bursts of 128, 128, 44 at ADDR 0, 128, 256; done=1, pass=1, err_cnt=0.
- Single corruption: len=256, word 200 returns 64'hDEAD → pass=0, err_cnt=1, err_addr=200.
- Stall hold: BUSY=1 for 5 cycles during the first REQ → RD, ADDR and BURSTCNT constant all 5 cycles; exactly one burst accepted.
- len=0 start → no RD asserted; done=1 and pass=1 within 2 cycles.
- Reset mid-burst: reset_n low after 10 of 128 beats → all outputs 0 immediately. A later start with len=16 scans cleanly to pass=1.
- CRC (macro defined): len=1, DOUT=0 → crc equals the reference CRC-32 of 8 zero bytes under the stated convention; start again → crc restarts and gives the same value.
